// File: rtl/rv_scoreboard.sv
// -----------------------------------------------------------------------------
// rv_scoreboard
//
// Issue-side register scoreboard. Records the destination registers of
// in-flight long-latency operations (loads, mul/div) whose results are not
// yet on any forwarding path, and stalls decode while the next instruction
// reads, or overwrites, a register that is still pending. Entries are pushed
// at issue and retired in order by the write stage.
//
// Parameters:
//   DEPTH  number of outstanding long-latency writes (power of two, 2..8)
//   CNT_W  width of o_count, clog2(DEPTH)+1
//
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   i_issue_valid/long/wr   issuing instruction qualifiers
//   i_issue_rd              destination of the issuing instruction
//   i_dec_rs1/rs2, i_dec_use_rs1/rs2  source operands and their use flags
//   i_wb_valid, i_wb_rd     in-order retire of a long-latency result
//   i_flush                 suppresses the push in this cycle
//   o_stall                 hold decode (combinational)
//   o_full, o_empty, o_count  occupancy, derived from registered state
//   o_err                   sticky retire-order / underflow error
//
// Optional build macro RV_SCB_PERF_EN adds o_stall_cycles[31:0], a saturating
// count of cycles in which o_stall was asserted.
// -----------------------------------------------------------------------------
module rv_scoreboard #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_issue_valid,
  input  logic             i_issue_long,
  input  logic [4:0]       i_issue_rd,
  input  logic             i_issue_wr,
  input  logic [4:0]       i_dec_rs1,
  input  logic [4:0]       i_dec_rs2,
  input  logic             i_dec_use_rs1,
  input  logic             i_dec_use_rs2,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic             o_err
`ifdef RV_SCB_PERF_EN
  ,
  output logic [31:0]      o_stall_cycles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       rd_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic full, empty, pop, push;
  logic hit_rs1, hit_rs2, hit_rd;
  logic hz1, hz2, waw;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = i_wb_valid & ~empty;

  // Hazard lookup. The head entry being retired this cycle is skipped: the
  // write stage forwards that value, so the consumer may issue alongside it.
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !(pop && (PTR_W'(i) == rp_q))) begin
        if (rd_q[i] == i_dec_rs1)  hit_rs1 = 1'b1;
        if (rd_q[i] == i_dec_rs2)  hit_rs2 = 1'b1;
        if (rd_q[i] == i_issue_rd) hit_rd  = 1'b1;
      end
    end
  end

  // x0 is never a dependency.
  assign hz1 = i_dec_use_rs1 & (i_dec_rs1 != 5'd0) & hit_rs1;
  assign hz2 = i_dec_use_rs2 & (i_dec_rs2 != 5'd0) & hit_rs2;
  assign waw = i_issue_wr    & (i_issue_rd != 5'd0) & hit_rd;

  // A retire in the same cycle does not relieve a full table: the full term
  // looks at registered occupancy only, which keeps this path short.
  assign o_stall = i_issue_valid & (hz1 | hz2 | waw | (i_issue_long & full));

  assign push = i_issue_valid & i_issue_long & (i_issue_rd != 5'd0) &
                ~o_stall & ~i_flush;

  always_comb begin
    valid_d = valid_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (pop) begin
      valid_d[rp_q] = 1'b0;
      rp_d          = rp_q + PTR_W'(1);
    end
    // Push and pop never target the same slot: a push needs a free slot,
    // and with a free slot at wp the head at rp is a different entry.
    if (push) begin
      valid_d[wp_q] = 1'b1;
      wp_d          = wp_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Retire on an empty table, or of a register other than the head, is a
    // pipeline bookkeeping fault; it latches until reset.
    if (i_wb_valid && (empty || (rd_q[rp_q] != i_wb_rd))) begin
      err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the register-number array has no reset; an entry is only ever
  // consulted when its valid bit (which is reset) is set.
  always_ff @(posedge i_clk) begin
    if (push) begin
      rd_q[wp_q] <= i_issue_rd;
    end
  end

  assign o_full  = full;
  assign o_empty = empty;
  assign o_count = cnt_q;
  assign o_err   = err_q;

`ifdef RV_SCB_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_cycles_q <= '0;
    end else if (o_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/rv_scoreboard.md
Name: rv_scoreboard

Overview:
- Issue-side register scoreboard: the producer-side counterpart to the execute-stage operand forwarding network.
- Tracks destination registers of in-flight long-latency ops (loads, mul/div) whose results are not yet available on any forwarding path.
- Stalls decode while a source or destination register of the next instruction is still pending.
- Sits between decode and execute. Issue pushes entries; the write stage retires them in order.

Parameters:
- DEPTH, 4, number of outstanding long-latency writes tracked; must be a power of two, 2..8.
- CNT_W, 3, width of o_count; equals clog2(DEPTH)+1.

Ports:
- i_clk  in  1  core clock
- i_reset_n  in  1  synchronous reset, active-low
- i_issue_valid  in  1  decode presents an instruction for issue this cycle
- i_issue_long  in  1  issuing instruction is long-latency and writes a register
- i_issue_rd  in  5  destination of the issuing instruction
- i_issue_wr  in  1  issuing instruction writes rd (any latency)
- i_dec_rs1  in  5  source 1 of the issuing instruction
- i_dec_rs2  in  5  source 2 of the issuing instruction
- i_dec_use_rs1  in  1  rs1 is read
- i_dec_use_rs2  in  1  rs2 is read
- i_wb_valid  in  1  write stage commits a long-latency result this cycle
- i_wb_rd  in  5  register committed by the write stage
- i_flush  in  1  pipeline flush; suppresses the push this cycle
- o_stall  out  1  hold decode; instruction must not issue
- o_full  out  1  DEPTH entries pending
- o_empty  out  1  no entries pending
- o_count  out  CNT_W  number of pending entries
- o_err  out  1  sticky: write-stage retire did not match the head entry

Behaviour:
- Storage: circular FIFO of DEPTH entries, each {valid, rd[4:0]}. Write pointer wp, read pointer rp, count cnt.
- Reset (i_reset_n=0 at posedge):
  - all valid bits, wp, rp, cnt and o_err cleared;
  - o_empty=1, o_full=0, o_count=0, o_err=0;
  - o_stall=0, because it is combinational and the table is empty.
- Pop: occurs when i_wb_valid=1 and cnt!=0.
  - Head entry invalidated; rp+1 modulo DEPTH; cnt-1.
  - If i_wb_rd != head rd, o_err is set and stays set until reset. The pop still happens.
  - i_wb_valid with cnt==0 is ignored and sets o_err.
- Hazard match (combinational): an entry matches register r if valid, r!=0, and entry rd==r.
  - The head entry is excluded from matching when it is popped in the same cycle. The write stage forwards that value, so it is a bypass with no stall.
- o_stall = i_issue_valid & ( hz1 | hz2 | waw | (i_issue_long & full_eff) ), where:
  - hz1 = i_dec_use_rs1 & match(i_dec_rs1);
  - hz2 = i_dec_use_rs2 & match(i_dec_rs2);
  - waw = i_issue_wr & match(i_issue_rd);
  - full_eff = cnt==DEPTH. A pop in the same cycle does not relieve a full stall.
- Push: occurs when i_issue_valid & i_issue_long & i_issue_rd!=0 & !o_stall & !i_flush.
  - Writes {1, i_issue_rd} at wp; wp+1 modulo DEPTH; cnt+1.
- Simultaneous push and pop: both take effect and cnt is unchanged. Pointers wrap independently.
- A long op with rd=x0 never pushes and never stalls on WAW.
- Flush does not remove pending entries. Already-issued long ops always complete and retire.
- o_full = cnt==DEPTH; o_empty = cnt==0; o_count = cnt. All are registered-state derived, with zero latency after the clock edge.
- Latency: entry visible to hazard checks the cycle after push; removal visible the same cycle as pop (bypass rule above).

Optional Feature:
- Macro: RV_SCB_PERF_EN.
- When defined, the block adds output o_stall_cycles [31:0]:
  - increments each cycle o_stall=1;
  - saturates at 0xFFFFFFFF;
  - cleared by reset.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle, all valid inputs low -> o_empty=1, o_count=0, o_stall=0, o_err=0.
- Issue long rd=5; next cycle issue with use_rs1=1, rs1=5 -> o_stall=1. The stall holds until i_wb_valid,rd=5; in that wb cycle o_stall=0 (bypass), and o_count goes 1 to 0.
- Push 4 long ops rd=1,2,3,4 -> o_full=1, o_count=4. A fifth long issue rd=6 stalls even with a simultaneous wb pop of rd=1. The following cycle it issues and o_count=4.
- Long issue rd=0 -> no push, o_count stays 0. Then a short issue with i_issue_wr=1, rd=7 while rd=7 is pending -> o_stall=1 (WAW).
- Pending rd=3, then i_wb_valid with rd=9 -> o_err=1 and sticky. The entry still pops, o_count=0.
- i_flush=1 with a long issue rd=8 -> no push. Retire of existing entries continues and the pointers wrap correctly after 9 push/pop pairs.
